fp16_to_fixed: RTL and testbench

- Pipelined converter from IEEE-754 binary16 to signed two's-complement fixed point. It performs the reverse of the float16 datapath's normalize/round/pack step.
- Feeds fixed-point post-processing (LUT indexing, integer accumulators) in the activation accelerator.
- Valid/ready streaming on both sides. Throughput 1 conversion/cycle, latency 2 cycles when not stalled.
- Rounds to nearest, ties to even. Saturates on overflow and Inf. Maps NaN to 0 with a flag.

---
 rtl/fp16_pkg.sv | 18 +
 rtl/fp16_unpack.sv | 17 +
 rtl/fp16_to_fixed.sv | 112 +++++++++++
 tb/tb_fp16_to_fixed.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// fp16_pkg: shared binary16 field widths, constants and classification helper.
package fp16_pkg;
    localparam int FP16_EXP_W  = 5;
    localparam int FP16_MANT_W = 10;
    localparam int FP16_BIAS   = 15;
    localparam logic [15:0] FP16_QNAN = 16'h7E00;

    typedef enum logic [2:0] {FP_ZERO, FP_SUB, FP_NORM, FP_INF, FP_NAN} fp16_class_e;

    function automatic fp16_class_e fp16_classify(input logic [15:0] x);
        logic [FP16_EXP_W-1:0] e;
        logic [FP16_MANT_W-1:0] m;
        e = x[FP16_MANT_W +: FP16_EXP_W];
        m = x[FP16_MANT_W-1:0];
        return (&e) ? ((|m) ? FP_NAN : FP_INF) :
               (e == '0) ? ((|m) ? FP_SUB : FP_ZERO) : FP_NORM;
    endfunction
endpackage

// File: rtl/fp16_unpack.sv
// fp16_unpack: splits a binary16 value into sign, class, significand and effective exponent.
module fp16_unpack
    import fp16_pkg::*;
(
    input  logic [15:0]              x,
    output logic                     sign,
    output fp16_class_e              cls,
    output logic [FP16_MANT_W:0]     m,
    output logic [FP16_EXP_W-1:0]    e_eff
);
    logic denorm;
    assign sign   = x[15];
    assign cls    = fp16_classify(x);
    assign denorm = (cls == FP_ZERO) || (cls == FP_SUB);
    assign m      = {!denorm, x[FP16_MANT_W-1:0]};
    assign e_eff  = denorm ? FP16_EXP_W'(1) : x[FP16_MANT_W +: FP16_EXP_W];
endmodule

// File: rtl/fp16_to_fixed.sv
// fp16_to_fixed: two-stage valid/ready converter from binary16 to signed fixed point,
// round-to-nearest-even with saturation and NaN flagging.
module fp16_to_fixed
    import fp16_pkg::*;
#(
    parameter int OUT_W  = 24,
    parameter int FRAC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    output logic             out_nan,
    output logic             out_inexact
);
    // Wide enough for an 11-bit significand shifted by the largest legal left shift.
    localparam int WW = OUT_W + 16;
    localparam logic [WW-1:0]    LIM   = WW'(1) << (OUT_W - 1);
    localparam logic [OUT_W:0]   MAXP  = {2'b00, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W:0]   MAXN  = {2'b01, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] SAT_P = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_N = {1'b1, {(OUT_W-1){1'b0}}};

    logic                    sign;
    fp16_class_e             cls;
    logic [FP16_MANT_W:0]    m;
    logic [FP16_EXP_W-1:0]   e_eff;

    fp16_unpack u_unpack (
        .x     (in_data),
        .sign  (sign),
        .cls   (cls),
        .m     (m),
        .e_eff (e_eff)
    );

    logic signed [6:0] sh;
    logic [6:0]        rsh;
    logic [3:0]        rn;
    logic [23:0]       rt;
    logic [WW-1:0]     wide;
    logic              ovf1, g1, s1;

    assign sh   = 7'(e_eff) - 7'(FP16_BIAS + FP16_MANT_W) + 7'(FRAC_W);
    assign rsh  = 7'(-sh);
    // Right shifts past 12 all leave only sticky; clamp to keep the shifter narrow.
    assign rn   = (rsh > 7'd13) ? 4'd13 : rsh[3:0];
    assign rt   = {m, 13'b0} >> rn;
    assign wide = sh[6] ? WW'(rt[23:13]) : (WW'(m) << sh[5:0]);
    assign ovf1 = (wide > LIM) || (wide == LIM && !sign);
    assign g1   = sh[6] && rt[12];
    assign s1   = sh[6] && (|rt[11:0]);

    logic             s1_valid, s1_sign, s1_nan, s1_inf, s1_ovf, s1_g, s1_s;
    logic [OUT_W:0]   s1_mag;
    logic             adv1, adv2;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    logic             rnd, sat, ovf2, inx2;
    logic [OUT_W:0]   mag_r;
    logic [OUT_W-1:0] data2;

    always_comb begin
        rnd   = s1_g && (s1_s || s1_mag[0]);
        mag_r = s1_mag + (OUT_W+1)'(rnd);
        sat   = s1_inf || s1_ovf || (s1_sign ? (mag_r > MAXN) : (mag_r > MAXP));
        data2 = s1_nan ? '0 : sat ? (s1_sign ? SAT_N : SAT_P) :
                s1_sign ? OUT_W'(-mag_r) : mag_r[OUT_W-1:0];
        ovf2  = !s1_nan && sat;
        inx2  = !s1_nan && !sat && (s1_g || s1_s);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_ovf     <= 1'b0;
            out_nan     <= 1'b0;
            out_inexact <= 1'b0;
        end else begin
            if (adv1) s1_valid <= in_valid;
            if (adv2) out_valid <= s1_valid;
            if (adv2 && s1_valid) begin
                out_data    <= data2;
                out_ovf     <= ovf2;
                out_nan     <= s1_nan;
                out_inexact <= inx2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            s1_sign <= sign;
            s1_nan  <= cls == FP_NAN;
            s1_inf  <= cls == FP_INF;
            s1_ovf  <= ovf1;
            s1_mag  <= wide[OUT_W:0];
            s1_g    <= g1;
            s1_s    <= s1;
        end
    end
endmodule

// File: tb/tb_fp16_to_fixed.sv
// tb_fp16_to_fixed: random and directed stimulus checked against an arithmetic model of the conversion.
module tb_fp16_to_fixed;
    localparam int OUT_W  = 24;
    localparam int FRAC_W = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf, out_nan, out_inexact;

    fp16_to_fixed #(.OUT_W(OUT_W), .FRAC_W(FRAC_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ovf     (out_ovf),
        .out_nan     (out_nan),
        .out_inexact (out_inexact)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [OUT_W+2:0] q[$];
    logic             prev_stall = 1'b0;
    logic [OUT_W+2:0] held, got, expv;
    logic [15:0]      sp[8];

    // Result packed as {ovf, nan, inexact, data}; value = significand * 2^(exp-25), scaled by 2^FRAC_W.
    function automatic logic [OUT_W+2:0] model(input logic [15:0] x);
        longint maxv, minv, mm, qv, den, rm, sv;
        int p;
        logic inx;
        logic [OUT_W-1:0] sat_p, sat_n;
        maxv  = (longint'(1) <<< (OUT_W - 1)) - 1;
        minv  = -(longint'(1) <<< (OUT_W - 1));
        sat_p = OUT_W'(maxv);
        sat_n = OUT_W'(minv);
        inx   = 1'b0;
        if (x[14:10] == 5'd31)
            return (x[9:0] != 0) ? {3'b010, {OUT_W{1'b0}}} : {3'b100, (x[15] ? sat_n : sat_p)};
        mm = (x[14:10] == 0) ? longint'(x[9:0]) : longint'(x[9:0]) + 1024;
        p  = ((x[14:10] == 0) ? 1 : int'(x[14:10])) - 25 + FRAC_W;
        if (p >= 0) begin
            qv = mm <<< p;
        end else begin
            den = longint'(1) <<< ((p < -40) ? 40 : -p);
            qv  = mm / den;
            rm  = mm % den;
            inx = rm != 0;
            if (2 * rm > den || (2 * rm == den && qv[0])) qv++;
        end
        sv = x[15] ? -qv : qv;
        if (sv > maxv || sv < minv) return {3'b100, (x[15] ? sat_n : sat_p)};
        return {2'b00, inx, sv[OUT_W-1:0]};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            got = {out_ovf, out_nan, out_inexact, out_data};
            if (prev_stall) begin
                total++;
                if (!out_valid || got !== held) begin
                    bad++;
                    $display("FAIL hold: valid=%b got=%h required=%h", out_valid, got, held);
                end
            end
            prev_stall = out_valid && !out_ready;
            held = got;
            total++;
            if (in_ready !== !(q.size() == 2 && !out_ready)) begin
                bad++;
                $display("FAIL in_ready: got=%b occupancy=%0d out_ready=%b", in_ready, q.size(), out_ready);
            end
            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected output: got=%h required=none", got);
                end else begin
                    expv = q.pop_front();
                    if (got !== expv) begin
                        bad++;
                        $display("FAIL out {ovf,nan,inx,data}: got=%h required=%h", got, expv);
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(model(in_data));
        end
    end

    task automatic send1(input logic [15:0] x, input logic [OUT_W+2:0] lit);
        int n;
        logic seen;
        total++;
        if (model(x) !== lit) begin
            bad++;
            $display("FAIL model pin x=%h: got=%h required=%h", x, model(x), lit);
        end
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data = x;
        out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            @(negedge clk);
            n++;
            seen = out_valid;
        end
        total++;
        if (!seen || n != 2) begin
            bad++;
            $display("FAIL latency x=%h: got=%0d required=2 (seen=%b)", x, n, seen);
        end
        total++;
        if ({out_ovf, out_nan, out_inexact, out_data} !== lit) begin
            bad++;
            $display("FAIL directed x=%h: got=%h required=%h", x, {out_ovf, out_nan, out_inexact, out_data}, lit);
        end
    endtask

    initial begin
        int nout;
        sp = '{16'h7C00, 16'hFC00, 16'h7E00, 16'h8000, 16'h6800, 16'hE800, 16'h0001, 16'h8001};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset handshake: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        total++;
        if ({out_ovf, out_nan, out_inexact, out_data} !== '0) begin
            bad++;
            $display("FAIL reset data: got=%h required=0", {out_ovf, out_nan, out_inexact, out_data});
        end

        send1(16'h3C00, {3'b000, 24'h001000});
        send1(16'hC100, {3'b000, 24'hFFD800});
        send1(16'hB800, {3'b000, 24'hFFF800});
        send1(16'h7BFF, {3'b100, 24'h7FFFFF});
        send1(16'hE800, {3'b000, 24'h800000});
        send1(16'h6800, {3'b100, 24'h7FFFFF});
        send1(16'hFC00, {3'b100, 24'h800000});
        send1(16'h7C00, {3'b100, 24'h7FFFFF});
        send1(16'h0800, {3'b001, 24'h000000});
        send1(16'h0E00, {3'b001, 24'h000002});
        send1(16'h0001, {3'b001, 24'h000000});
        send1(16'h7E00, {3'b010, 24'h000000});
        send1(16'h8000, {3'b000, 24'h000000});

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom % 4) != 0;
            in_data   = (($urandom % 8) == 0) ? sp[$urandom % 8] : 16'($urandom);
            out_ready = ((c / 500) % 2 == 1) ? (($urandom % 4) == 0) : (($urandom % 3) != 0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending required=0", q.size());
        end

        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h3C00;
        @(posedge clk); #1;
        in_data = 16'hC100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset flush: out_valid=%b required=0", out_valid);
        end
        nout = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) nout++;
        end
        total++;
        if (nout != 0) begin
            bad++;
            $display("FAIL flushed items emitted: got=%0d required=0", nout);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
